// File: rtl/decode_in_capture.sv
// rtl/decode_in_capture.sv - decode_in beat capture FWFT FIFO with drop/txn counters and NPC check
// Optional macro DECODE_IN_CAPTURE_TIMESTAMP_EN adds a per-beat cycle timestamp and the cap_ts port.
module decode_in_capture #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    parameter int OVF_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_decode,
    input  logic [15:0]      Instr_dout,
    input  logic [15:0]      npc_in,
    output logic             cap_valid,
    input  logic             cap_ready,
    output logic [15:0]      cap_instr,
    output logic [15:0]      cap_npc,
`ifdef DECODE_IN_CAPTURE_TIMESTAMP_EN
    output logic [15:0]      cap_ts,
`endif
    output logic             full,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [OVF_W-1:0] ovf_cnt,
    output logic             seq_err
);
    localparam int PTR_W = $clog2(DEPTH);
`ifdef DECODE_IN_CAPTURE_TIMESTAMP_EN
    localparam int ENT_W = 48;
`else
    localparam int ENT_W = 32;
`endif
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] entry_d;
    logic [ENT_W-1:0] head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
    logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic             seq_err_q, seq_err_d;
    logic             have_prev_q, have_prev_d;
    logic [15:0]      prev_npc_q, prev_npc_d;

    logic is_empty, is_full, pop, accept, drop;

`ifdef DECODE_IN_CAPTURE_TIMESTAMP_EN
    logic [15:0] ts_q, ts_d;

    always_comb begin
        ts_d = ts_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q <= 16'd0;
        end else begin
            ts_q <= ts_d;
        end
    end
`endif

    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == FULL_CNT);
        pop      = !is_empty && cap_ready;
        // A full FIFO still accepts a beat when the head leaves on the same edge.
        accept   = enable_decode && (!is_full || pop);
        drop     = enable_decode && is_full && !pop;
`ifdef DECODE_IN_CAPTURE_TIMESTAMP_EN
        entry_d  = {Instr_dout, npc_in, ts_q};
`else
        entry_d  = {Instr_dout, npc_in};
`endif
    end

    always_comb begin
        wr_ptr_d    = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        txn_cnt_d   = accept ? txn_cnt_q + CNT_W'(1) : txn_cnt_q;
        ovf_cnt_d   = (drop && (ovf_cnt_q != '1)) ? ovf_cnt_q + OVF_W'(1) : ovf_cnt_q;
        seq_err_d   = seq_err_q;
        have_prev_d = have_prev_q;
        prev_npc_d  = prev_npc_q;
        if (accept) begin
            // 16-bit wrap makes FFFF -> 0000 a legal successor.
            if (have_prev_q && (npc_in != prev_npc_q + 16'd1)) begin
                seq_err_d = 1'b1;
            end
            have_prev_d = 1'b1;
            prev_npc_d  = npc_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            txn_cnt_q   <= '0;
            ovf_cnt_q   <= '0;
            seq_err_q   <= 1'b0;
            have_prev_q <= 1'b0;
            prev_npc_q  <= 16'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            txn_cnt_q   <= txn_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            seq_err_q   <= seq_err_d;
            have_prev_q <= have_prev_d;
            prev_npc_q  <= prev_npc_d;
        end
    end

    // Storage needs no reset: contents are masked by the occupancy count.
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            mem_q[wr_ptr_q] <= entry_d;
        end
    end

    always_comb begin
        head      = mem_q[rd_ptr_q];
        cap_valid = !is_empty;
        full      = is_full;
        cap_instr = is_empty ? 16'd0 : head[ENT_W-1 -: 16];
        cap_npc   = is_empty ? 16'd0 : head[ENT_W-17 -: 16];
`ifdef DECODE_IN_CAPTURE_TIMESTAMP_EN
        cap_ts    = is_empty ? 16'd0 : head[15:0];
`endif
        txn_cnt   = txn_cnt_q;
        ovf_cnt   = ovf_cnt_q;
        seq_err   = seq_err_q;
    end
endmodule
